// File: rtl/scpad_tile_arbiter.sv
// scpad_tile_arbiter: per-scratchpad round-robin arbiter and tile-row burst
// sequencer. Requester 0 = prefetcher, 1 = SA frontend, 2 = VC frontend.
// Optional: define SCPAD_ARB_PERF_EN to add per-scratchpad stall/beat counters.

// One scratchpad's arbiter + burst sequencer. A granted command owns the
// scratchpad until its last row beat is accepted.
module scpad_seq #(
  parameter int NUM_REQ       = 3,
  parameter int MAX_TILE_ROWS = 32,
  parameter int CNT_W         = 6,
  parameter int ROW_W         = 14,
  parameter int OWN_W         = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              cand,
  input  logic [NUM_REQ-1:0][ROW_W-1:0]   base_in,
  input  logic [NUM_REQ-1:0][CNT_W-1:0]   rows_in,
  input  logic [NUM_REQ-1:0]              write_in,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              done,
  output logic                            sram_valid,
  input  logic                            sram_ready,
  output logic [ROW_W-1:0]                sram_row,
  output logic                            sram_write,
  output logic [OWN_W-1:0]                sram_owner
`ifdef SCPAD_ARB_PERF_EN
  ,
  output logic [31:0]                     stall_cnt,
  output logic [31:0]                     beat_cnt
`endif
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]       state;
  logic [OWN_W-1:0] rr_ptr;
  logic [ROW_W-1:0] base;
  logic [CNT_W-1:0] nrows;
  logic [CNT_W-1:0] idx;
  logic             wr;
  logic [OWN_W-1:0] owner;

  logic             found;
  logic [OWN_W-1:0] win;
  logic [CNT_W-1:0] rows_sel;
  logic [CNT_W-1:0] rows_clamped;
  logic             busy;

  // Round-robin pick: first candidate at or above rr_ptr, wrapping; only while idle
  always_comb begin : arb
    int pos;
    grant = '0;
    win   = '0;
    found = 1'b0;
    pos   = 0;
    if (state == IDLE) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        pos = int'(rr_ptr) + k;
        if (pos >= NUM_REQ) pos = pos - NUM_REQ;
        if (!found && cand[pos]) begin
          found = 1'b1;
          win   = OWN_W'(pos);
        end
      end
      if (found) grant[win] = 1'b1;
    end
  end

  // Oversized row counts are clamped to the maximum tile height
  assign rows_sel     = rows_in[win];
  assign rows_clamped = (rows_sel > CNT_W'(MAX_TILE_ROWS)) ? CNT_W'(MAX_TILE_ROWS) : rows_sel;

  // Latch the granted command, then step one row per accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      base   <= '0;
      nrows  <= '0;
      wr     <= 1'b0;
      owner  <= '0;
      idx    <= '0;
      done   <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: if (found) begin
          base   <= base_in[win];
          nrows  <= rows_clamped;
          wr     <= write_in[win];
          owner  <= win;
          idx    <= '0;
          rr_ptr <= (win == OWN_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
          // zero-row command completes without touching the SRAM
          if (rows_clamped == '0) done[win] <= 1'b1;
          else                    state     <= BURST;
        end
        BURST: if (sram_ready) begin
          idx <= idx + 1'b1;
          if (idx == nrows - 1'b1) begin
            state       <= IDLE;
            done[owner] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Beat outputs are zero whenever no burst is in flight; the row wraps at 2^ROW_W
  assign busy       = (state == BURST);
  assign sram_valid = busy;
  assign sram_row   = busy ? (base + ROW_W'(idx)) : '0;
  assign sram_write = busy & wr;
  assign sram_owner = busy ? owner : '0;

`ifdef SCPAD_ARB_PERF_EN
  // Free-running wrapping counters of stalled cycles and accepted beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      beat_cnt  <= '0;
    end else begin
      if (sram_valid && !sram_ready) stall_cnt <= stall_cnt + 32'd1;
      if (sram_valid &&  sram_ready) beat_cnt  <= beat_cnt + 32'd1;
    end
  end
`endif

endmodule

module scpad_tile_arbiter #(
  parameter  int NUM_REQ        = 3,
  parameter  int MAX_TILE_ROWS  = 32,
  parameter  int CNT_W          = $clog2(MAX_TILE_ROWS) + 1,
  localparam int ROW_IDX_WIDTH  = 14,
  localparam int SCPAD_ID_WIDTH = 1,
  localparam int NUM_SCPADS     = 2,
  localparam int OWN_W          = $clog2(NUM_REQ)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQ-1:0]                       req_valid,
  output logic [NUM_REQ-1:0]                       req_ready,
  input  logic [NUM_REQ-1:0][SCPAD_ID_WIDTH-1:0]   req_scpad_id,
  input  logic [NUM_REQ-1:0][ROW_IDX_WIDTH-1:0]    req_base_row,
  input  logic [NUM_REQ-1:0][CNT_W-1:0]            req_num_rows,
  input  logic [NUM_REQ-1:0]                       req_write,
  output logic [NUM_REQ-1:0]                       done,
  output logic [NUM_SCPADS-1:0]                    sram_valid,
  input  logic [NUM_SCPADS-1:0]                    sram_ready,
  output logic [NUM_SCPADS-1:0][ROW_IDX_WIDTH-1:0] sram_row,
  output logic [NUM_SCPADS-1:0]                    sram_write,
  output logic [NUM_SCPADS-1:0][OWN_W-1:0]         sram_owner
`ifdef SCPAD_ARB_PERF_EN
  ,
  output logic [NUM_SCPADS-1:0][31:0]              perf_stall_cnt,
  output logic [NUM_SCPADS-1:0][31:0]              perf_beat_cnt
`endif
);

  logic [NUM_REQ-1:0] cand   [NUM_SCPADS];
  logic [NUM_REQ-1:0] grant  [NUM_SCPADS];
  logic [NUM_REQ-1:0] done_s [NUM_SCPADS];

  // Route each requester to the scratchpad it targets
  always_comb begin
    for (int s = 0; s < NUM_SCPADS; s++) begin
      cand[s] = '0;
      for (int r = 0; r < NUM_REQ; r++)
        cand[s][r] = req_valid[r] && (req_scpad_id[r] == SCPAD_ID_WIDTH'(s));
    end
  end

  // A requester targets one scratchpad per command, so OR-merging never double-grants
  always_comb begin
    req_ready = '0;
    done      = '0;
    for (int s = 0; s < NUM_SCPADS; s++) begin
      req_ready = req_ready | grant[s];
      done      = done | done_s[s];
    end
    if (rst) req_ready = '0;
  end

  for (genvar s = 0; s < NUM_SCPADS; s++) begin : g_scpad
    scpad_seq #(
      .NUM_REQ       (NUM_REQ),
      .MAX_TILE_ROWS (MAX_TILE_ROWS),
      .CNT_W         (CNT_W),
      .ROW_W         (ROW_IDX_WIDTH),
      .OWN_W         (OWN_W)
    ) u_seq (
      .clk        (clk),
      .rst        (rst),
      .cand       (cand[s]),
      .base_in    (req_base_row),
      .rows_in    (req_num_rows),
      .write_in   (req_write),
      .grant      (grant[s]),
      .done       (done_s[s]),
      .sram_valid (sram_valid[s]),
      .sram_ready (sram_ready[s]),
      .sram_row   (sram_row[s]),
      .sram_write (sram_write[s]),
      .sram_owner (sram_owner[s])
`ifdef SCPAD_ARB_PERF_EN
      ,
      .stall_cnt  (perf_stall_cnt[s]),
      .beat_cnt   (perf_beat_cnt[s])
`endif
    );
  end

endmodule
